dmem_responder: RTL and testbench

//  Responder (memory side) of the CPU load/store port: accepts one word access per handshake,

---
 rtl/cpu_mem_pkg.sv | 28 ++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port: responder FSM states,
// word geometry and the address legality check.
package cpu_mem_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int WORD_BYTES     = 4;
  localparam int OFS_W          = $clog2(WORD_BYTES);
  localparam int DEFAULT_DATA_W = 32;
  localparam int CNT_W          = 4;   // wait counter, holds latencies 0..15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An access is rejected when it is not word aligned, or when any byte-address
  // bit above the word index is set (beyond the end of the array).
  function automatic logic addr_err(input logic [ADDR_BITS-1:0] adr, input int addr_w);
    logic e;
    e = (adr[OFS_W-1:0] != '0);
    for (int i = OFS_W; i < ADDR_BITS; i++) begin
      if (i >= addr_w + OFS_W) e = e | adr[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array. One access per enabled edge: a store
// writes the word, a load registers the word onto rdata. rdata only changes on
// loads, so it naturally holds the last loaded word.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write or registered read of the addressed word.
  // NOTE: the storage array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM, and its contents are defined by stores.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder of the CPU load/store port. Accepts one word access per
// handshake, waits a fixed number of cycles, performs the access on the array
// and returns a one-cycle ack (with err for rejected addresses).
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] adr,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 ack,
  output logic [DATA_W-1:0]    rdata,
  output logic                 err,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q;
  logic [ADDR_BITS-1:0] adr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 accept;
  logic                 done;
  logic                 acc_err;
  logic                 mem_en;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 rd_valid;

  // The counter is loaded with LATENCY on accept and the FSM leaves WAIT on the
  // edge where it has reached zero, so the access (and RESP entry) lands on
  // edge E0+LATENCY+1 and the ack cycle follows it.
  assign accept  = (state == ST_IDLE) && req;
  assign done    = (state == ST_WAIT) && (cnt == '0);
  assign acc_err = addr_err(adr_q, ADDR_W);
  assign mem_en  = done && !acc_err;

  // Next-state logic for IDLE -> WAIT -> RESP -> IDLE; req is not looked at in RESP.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req)  state_nxt = ST_WAIT;
      ST_WAIT: if (done) state_nxt = ST_RESP;
      ST_RESP:           state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Request latch and wait counter; inputs are only sampled on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(LATENCY);
      we_q    <= we;
      adr_q   <= adr;
      wdata_q <= wdata;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt     <= cnt - 1'b1;
    end
  end

  // Registered handshake outputs: ack/err for the RESP cycle, busy from accept to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      ack <= done;
      err <= done && acc_err;
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;
      if (mem_en && !we_q) rd_valid <= 1'b1;
    end
  end

  // The array's read register is not reset; rd_valid masks it to zero until
  // the first successful load after reset.
  assign rdata = rd_valid ? mem_rdata : '0;

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (we_q),
    .idx  (adr_q[ADDR_W+OFS_W-1:OFS_W]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=2 instance and one
// LATENCY=0 instance, directed accesses with a scoreboard of expected results.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] adr   [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [2][256];
  logic [31:0] last_rd   [2];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .adr(adr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .adr(adr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Model the access and queue the result the DUT must return with its ack.
  task automatic push_exp(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    logic e;
    e = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    if (!e && w)  model_mem[d][a[9:2]] = wd;
    if (!e && !w) last_rd[d] = model_mem[d][a[9:2]];
    sb.push_back('{rdata: last_rd[d], err: e});
  endtask

  task automatic pop_check(input int d, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " rdata"}, rdata[d], e.rdata);
      check({tag, " err"}, {31'd0, err[d]}, {31'd0, e.err});
    end
  endtask

  // One complete handshake, starting and ending at a falling edge. Inputs are
  // scrambled while busy to show the latched copies are used.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int n;
    bit seen;
    push_exp(d, w, a, wd);
    req[d] = 1'b1; we[d] = w; adr[d] = a; wdata[d] = wd;
    @(posedge clk);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[d]) begin
        seen = 1;
      end else begin
        check({tag, " busy wait"}, {31'd0, busy[d]}, 32'd1);
        adr[d]   = $urandom;
        wdata[d] = $urandom;
        we[d]    = ~w;
      end
    end
    check({tag, " ack latency"}, n, lat_of(d) + 2);
    check({tag, " busy in ack"}, {31'd0, busy[d]}, 32'd0);
    pop_check(d, tag);
    req[d] = 1'b0;
    @(negedge clk);
    check({tag, " ack one cycle"}, {31'd0, ack[d]}, 32'd0);
    check({tag, " err low"}, {31'd0, err[d]}, 32'd0);
  endtask

  initial begin
    int acks;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; wdata[d] = '0; last_rd[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset ack",   {31'd0, ack[d]},  32'd0);
      check("reset err",   {31'd0, err[d]},  32'd0);
      check("reset busy",  {31'd0, busy[d]}, 32'd0);
      check("reset rdata", rdata[d], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Store then load the same word; latency and busy checked inside access.
    access(0, 1'b1, 32'h0000_0000, 32'h1111_1111, "st0");
    access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "st10");
    access(0, 1'b0, 32'h0000_0010, 32'h0,          "ld10");
    check("ld10 value", rdata[0], 32'hDEAD_BEEF);

    // Rejected accesses: misaligned load, out-of-range store (would alias word 0).
    access(0, 1'b0, 32'h0000_0013, 32'h0,          "ld13 err");
    check("held rdata", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 32'h0000_0400, 32'h0000_0BAD, "st400 err");
    access(0, 1'b1, 32'h8000_0000, 32'h0000_0BAD, "st hi err");
    access(0, 1'b0, 32'h0000_0000, 32'h0,          "ld0 after err");
    access(0, 1'b0, 32'h0000_0010, 32'h0,          "ld10 again");

    // Last valid word of the array.
    access(0, 1'b1, 32'h0000_03FC, 32'h0F0F_A5A5, "st3fc");
    access(0, 1'b0, 32'h0000_03FC, 32'h0,          "ld3fc");

    // Request held through the ack: one op per LATENCY+3 window.
    push_exp(0, 1'b0, 32'h0000_0010, 32'h0);
    push_exp(0, 1'b0, 32'h0000_0010, 32'h0);
    req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_0010;
    @(posedge clk);
    acks = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (ack[0]) begin
        acks++;
        check("hold ack pos", n, (acks == 1) ? 4 : 9);
        pop_check(0, "hold");
        if (acks == 2) req[0] = 1'b0;
      end
    end
    check("hold ack count", acks, 2);
    sb.delete();

    // Reset during WAIT aborts a store.
    access(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, "st20");
    req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0000_0020; wdata[0] = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    check("abort busy before rst", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy in rst", {31'd0, busy[0]}, 32'd0);
    check("abort ack in rst",  {31'd0, ack[0]},  32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    check("abort no ack", acks, 0);
    check("abort busy after", {31'd0, busy[0]}, 32'd0);
    check("rdata cleared", rdata[0], 32'd0);
    access(0, 1'b0, 32'h0000_0020, 32'h0, "ld20 after abort");
    check("ld20 old value", rdata[0], 32'hCAFE_F00D);

    // Zero-latency instance: back-to-back store/load.
    access(1, 1'b1, 32'h0000_0004, 32'hA5A5_5A5A, "l0 st4");
    access(1, 1'b0, 32'h0000_0004, 32'h0,          "l0 ld4");
    check("l0 ld4 value", rdata[1], 32'hA5A5_5A5A);
    access(1, 1'b0, 32'h0000_0006, 32'h0,          "l0 ld6 err");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
